// File: rtl/pipe_stage_buf.sv
// Two-entry pipeline stage buffer (head + skid) carrying ctrl/data/tag bundles in order.
// Latency: 1 cycle from acceptance into an empty stage to out_valid; 1 entry/cycle sustained.
// Backpressure: in_ready is registered and drops only when both head and skid are full.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready upstream handshake; in_ctrl/in_data/in_tag entry fields
//   flush             synchronous squash of all held entries (highest priority)
//   out_valid/out_ready downstream handshake; out_ctrl/out_data/out_tag head fields
//   occupancy         number of held entries (0..2)
//   flush_cnt         saturating count of flushes that discarded at least one entry
module pipe_stage_buf #(
   parameter int DATA_W = 16,
   parameter int NDATA  = 3,
   parameter int CTRL_W = 7,
   parameter int TAG_W  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [CTRL_W-1:0]       in_ctrl,
   input  logic [NDATA*DATA_W-1:0] in_data,
   input  logic [TAG_W-1:0]        in_tag,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CTRL_W-1:0]       out_ctrl,
   output logic [NDATA*DATA_W-1:0] out_data,
   output logic [TAG_W-1:0]        out_tag,
   output logic [1:0]              occupancy,
   output logic [7:0]              flush_cnt
);

   localparam int DW = NDATA * DATA_W;

   // One buffered entry, stored at full parameter width.
   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DW-1:0]     data;
      logic [TAG_W-1:0]  tag;
   } entry_t;

   // Encoding equals the occupancy of each state.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;

   logic       r_in_ready;
   logic       r_out_valid;
   logic [1:0] r_occupancy;
   logic [7:0] r_flush_cnt;

   entry_t     r_head;
   entry_t     r_skid;
   entry_t     w_in_ent;

   logic       w_in_fire;
   logic       w_out_fire;
   logic       w_head_ld_in;
   logic       w_head_ld_skid;
   logic       w_skid_ld;
   logic       w_flush_cnt_inc;

   //------------------------------------------------------------------
   // Handshake qualification: flush blocks both transfers in its cycle.
   //------------------------------------------------------------------
   assign w_in_ent.ctrl = in_ctrl;
   assign w_in_ent.data = in_data;
   assign w_in_ent.tag  = in_tag;

   assign w_in_fire  = in_valid    & r_in_ready & ~flush;
   assign w_out_fire = r_out_valid & out_ready  & ~flush;

   // Only flushes that actually throw away an entry are counted; the
   // counter sticks at its maximum rather than wrapping.
   assign w_flush_cnt_inc = flush & (r_occupancy != 2'd0) & (r_flush_cnt != 8'hFF);

   //------------------------------------------------------------------
   // Next-state and register load selection.
   //------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = r_state;
      w_head_ld_in   = 1'b0;
      w_head_ld_skid = 1'b0;
      w_skid_ld      = 1'b0;

      if (flush) begin
         w_state_nxt = S_EMPTY;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_in_fire) begin
                  w_head_ld_in = 1'b1;
                  w_state_nxt  = S_ONE;
               end
            end
            S_ONE: begin
               if (w_in_fire && w_out_fire) begin
                  // Head leaves and is replaced directly: skid stays unused.
                  w_head_ld_in = 1'b1;
                  w_state_nxt  = S_ONE;
               end else if (w_in_fire) begin
                  w_skid_ld   = 1'b1;
                  w_state_nxt = S_TWO;
               end else if (w_out_fire) begin
                  w_state_nxt = S_EMPTY;
               end
            end
            S_TWO: begin
               // in_ready is low here, so only a drain can happen.
               if (w_out_fire) begin
                  w_head_ld_skid = 1'b1;
                  w_state_nxt    = S_ONE;
               end
            end
            default: begin
               w_state_nxt = S_EMPTY;
            end
         endcase
      end
   end

   //------------------------------------------------------------------
   // State register with registered handshake/status outputs, all
   // derived from the next state so they line up with it exactly.
   //------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_occupancy <= 2'd0;
         r_flush_cnt <= 8'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= (w_state_nxt != S_TWO);
         r_out_valid <= (w_state_nxt != S_EMPTY);
         r_occupancy <= w_state_nxt;
         if (w_flush_cnt_inc) begin
            r_flush_cnt <= r_flush_cnt + 8'd1;
         end
      end
   end

   //------------------------------------------------------------------
   // Entry storage. Flush does not clear the fields: out_data/out_tag
   // keep their last values while invalid, and out_ctrl is gated below.
   //------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head <= '0;
         r_skid <= '0;
      end else begin
         if (w_head_ld_in) begin
            r_head <= w_in_ent;
         end else if (w_head_ld_skid) begin
            r_head <= r_skid;
         end
         if (w_skid_ld) begin
            r_skid <= w_in_ent;
         end
      end
   end

   //------------------------------------------------------------------
   // Outputs. Control bits are forced to a bubble when nothing is valid
   // so downstream never acts on stale regWrite/memWrite bits.
   //------------------------------------------------------------------
   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_ctrl  = r_out_valid ? r_head.ctrl : '0;
   assign out_data  = r_head.data;
   assign out_tag   = r_head.tag;
   assign occupancy = r_occupancy;
   assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Testbench for pipe_stage_buf: directed vectors, scoreboard queue plus negedge monitor.
// Driver changes inputs 1 time unit after each rising edge and updates the model at the edge.
// Monitor compares all outputs on every falling edge and pops the scoreboard on each transfer.
module tb_pipe_stage_buf;

   localparam int DATA_W = 16;
   localparam int NDATA  = 3;
   localparam int CTRL_W = 7;
   localparam int TAG_W  = 4;
   localparam int DW     = NDATA * DATA_W;

   typedef struct packed {
      logic [CTRL_W-1:0] c;
      logic [DW-1:0]     d;
      logic [TAG_W-1:0]  t;
   } ent_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DW-1:0]     in_data;
   logic [TAG_W-1:0]  in_tag;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DW-1:0]     out_data;
   logic [TAG_W-1:0]  out_tag;
   logic [1:0]        occupancy;
   logic [7:0]        flush_cnt;

   // Reference model: queue of held entries, occupancy, flush counter and
   // the last head contents (visible on out_data/out_tag while invalid).
   ent_t q[$];
   int   m_occ  = 0;
   int   m_fc   = 0;
   ent_t m_last = '0;
   ent_t mon_e;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pipe_stage_buf #(
      .DATA_W(DATA_W),
      .NDATA (NDATA),
      .CTRL_W(CTRL_W),
      .TAG_W (TAG_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_ctrl  (in_ctrl),
      .in_data  (in_data),
      .in_tag   (in_tag),
      .flush    (flush),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_ctrl (out_ctrl),
      .out_data (out_data),
      .out_tag  (out_tag),
      .occupancy(occupancy),
      .flush_cnt(flush_cnt)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   // Model update at the rising edge, using the inputs the driver applied.
   task automatic step_model();
      bit in_f;
      bit out_f;
      in_f  = in_valid && (m_occ != 2) && !flush;
      out_f = (m_occ != 0) && out_ready && !flush;
      if (flush) begin
         if (m_occ != 0) begin
            if (m_fc < 255) m_fc++;
            m_last = q[0];
         end
         q.delete();
         m_occ = 0;
      end else begin
         if (in_f) q.push_back('{c: in_ctrl, d: in_data, t: in_tag});
         m_occ = m_occ + int'(in_f) - int'(out_f);
      end
   endtask

   // One clock of stimulus: apply at edge+1, take the edge, update model.
   task automatic drive(input logic v, input logic r, input logic f,
                        input logic [CTRL_W-1:0] c, input logic [DW-1:0] d,
                        input logic [TAG_W-1:0] t);
      in_valid  = v;
      out_ready = r;
      flush     = f;
      in_ctrl   = c;
      in_data   = d;
      in_tag    = t;
      @(posedge clk);
      if (rst) step_model();
      #1;
   endtask

   task automatic do_reset(input int cycles);
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
      q.delete();
      m_occ  = 0;
      m_fc   = 0;
      m_last = '0;
      repeat (cycles) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // Monitor: all outputs settle long before the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_out_valid", 64'(out_valid), 64'(0));
         chk("rst_out_ctrl",  64'(out_ctrl),  64'(0));
         chk("rst_out_data",  64'(out_data),  64'(0));
         chk("rst_out_tag",   64'(out_tag),   64'(0));
         chk("rst_occupancy", 64'(occupancy), 64'(0));
         chk("rst_flush_cnt", 64'(flush_cnt), 64'(0));
         chk("rst_in_ready",  64'(in_ready),  64'(1));
      end else begin
         chk("in_ready",  64'(in_ready),  64'(m_occ != 2));
         chk("out_valid", 64'(out_valid), 64'(m_occ != 0));
         chk("occupancy", 64'(occupancy), 64'(m_occ));
         chk("flush_cnt", 64'(flush_cnt), 64'(m_fc));
         if (m_occ == 0) begin
            chk("bubble_ctrl", 64'(out_ctrl), 64'(0));
            chk("hold_data",   64'(out_data), 64'(m_last.d));
            chk("hold_tag",    64'(out_tag),  64'(m_last.t));
         end
         if (m_occ != 0 && out_ready && !flush) begin
            if (q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL sb_underflow at %0t: got empty scoreboard, expected an entry", $time);
            end else begin
               mon_e = q.pop_front();
               chk("out_ctrl", 64'(out_ctrl), 64'(mon_e.c));
               chk("out_data", 64'(out_data), 64'(mon_e.d));
               chk("out_tag",  64'(out_tag),  64'(mon_e.t));
               m_last = mon_e;
            end
         end
      end
   end

   initial begin
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
      in_ctrl   = '0;
      in_data   = '0;
      in_tag    = '0;
      do_reset(3);

      // First transfer right after reset release: tag 3, word0 = 16'h1234.
      drive(1, 1, 0, 7'h15, {16'h0000, 16'h0000, 16'h1234}, 4'd3);
      drive(0, 1, 0, 7'h00, '0, 4'd0);
      drive(0, 1, 0, 7'h00, '0, 4'd0);

      // Stall: A and B accepted, C held upstream, then drained in order.
      drive(1, 0, 0, 7'h01, {16'hA002, 16'hA001, 16'hA000}, 4'hA);
      drive(1, 0, 0, 7'h02, {16'hB002, 16'hB001, 16'hB000}, 4'hB);
      drive(1, 0, 0, 7'h04, {16'hC002, 16'hC001, 16'hC000}, 4'hC);
      drive(1, 0, 0, 7'h04, {16'hC002, 16'hC001, 16'hC000}, 4'hC);
      drive(1, 1, 0, 7'h04, {16'hC002, 16'hC001, 16'hC000}, 4'hC);
      drive(1, 1, 0, 7'h04, {16'hC002, 16'hC001, 16'hC000}, 4'hC);
      drive(0, 1, 0, 7'h00, '0, 4'd0);
      drive(0, 1, 0, 7'h00, '0, 4'd0);

      // Flush with two held entries and a same-cycle input that must be dropped.
      drive(1, 0, 0, 7'h11, {16'h1102, 16'h1101, 16'h1100}, 4'h1);
      drive(1, 0, 0, 7'h22, {16'h2202, 16'h2201, 16'h2200}, 4'h2);
      drive(1, 1, 1, 7'h33, {16'h3302, 16'h3301, 16'h3300}, 4'h3);
      drive(0, 1, 0, 7'h00, '0, 4'd0);
      drive(0, 1, 0, 7'h00, '0, 4'd0);

      // Back-to-back streaming at full rate.
      for (int i = 0; i < 20; i++) begin
         drive(1, 1, 0, 7'(i + 1), {16'(i * 7), 16'(i + 100), 16'(i)}, 4'(i));
      end
      drive(0, 1, 0, 7'h00, '0, 4'd0);

      // 260 flushes each discarding one entry: counter saturates at 255.
      for (int i = 0; i < 260; i++) begin
         drive(1, 0, 0, 7'h7F, {16'(i), 16'(i), 16'(i)}, 4'(i));
         drive(0, 0, 1, 7'h00, '0, 4'd0);
      end
      // Flush while empty leaves the counter unchanged.
      drive(0, 0, 1, 7'h00, '0, 4'd0);
      drive(0, 1, 0, 7'h00, '0, 4'd0);

      // Reset mid-stream with two entries held, then resume.
      drive(1, 0, 0, 7'h0A, {16'hD002, 16'hD001, 16'hD000}, 4'hD);
      drive(1, 0, 0, 7'h0B, {16'hE002, 16'hE001, 16'hE000}, 4'hE);
      do_reset(2);
      drive(1, 1, 0, 7'h0C, {16'hF002, 16'hF001, 16'hF000}, 4'hF);
      drive(1, 0, 0, 7'h0D, {16'h9002, 16'h9001, 16'h9000}, 4'h9);
      drive(0, 1, 0, 7'h00, '0, 4'd0);
      drive(0, 1, 0, 7'h00, '0, 4'd0);
      drive(0, 1, 0, 7'h00, '0, 4'd0);

      // Mixed valid/ready patterns with occasional flushes.
      for (int i = 0; i < 400; i++) begin
         drive((i % 3) != 0, ((i % 5) != 1) && ((i % 7) != 3), (i % 61) == 60,
               7'(i * 5 + 1), {16'(i * 3), 16'(i ^ 16'h5A5A), 16'(i + 1)}, 4'(i));
      end

      // Drain whatever is left.
      repeat (5) drive(0, 1, 0, 7'h00, '0, 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
